// File: rtl/ucode_pkg.sv
// Shared types and default dispatch table for the microcode dispatcher/sequencer.
// The optional writable base table is enabled with the UCODE_BASE_WR_EN macro.
package ucode_pkg;

    localparam int OPC_W     = 4;
    localparam int FN_W      = 5;
    localparam int UPC_W     = 16;
    localparam int NUM_DISP  = 4;
    localparam int DISP_OPC0 = 6;
    localparam int MAX_UOPS  = 64;

    typedef logic [UPC_W-1:0] upc_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } useq_state_t;

    // Index 0 belongs to DISP_OPC0, index 3 to DISP_OPC0+3.
    localparam logic [NUM_DISP-1:0][UPC_W-1:0] DEF_BASE = {16'h0056, 16'h0036, 16'h0026, 16'h0006};
    localparam logic [NUM_DISP-1:0][FN_W-1:0]  DEF_MASK = {5'h1F, 5'h1F, 5'h0F, 5'h0F};

    function automatic upc_t default_base(input int k);
        upc_t r;
        r = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            if (i == k) r = DEF_BASE[i];
        end
        return r;
    endfunction

    function automatic logic [FN_W-1:0] default_mask(input int k);
        logic [FN_W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DISP; i++) begin
            if (i == k) r = DEF_MASK[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/ucode_entry_calc.sv
// Combinational entry micro-PC: dispatch opcodes use base[k] + masked fn, others zero-extend.
module ucode_entry_calc
    import ucode_pkg::*;
#(
    parameter int OPC_W     = ucode_pkg::OPC_W,
    parameter int FN_W      = ucode_pkg::FN_W,
    parameter int UPC_W     = ucode_pkg::UPC_W,
    parameter int NUM_DISP  = ucode_pkg::NUM_DISP,
    parameter int DISP_OPC0 = ucode_pkg::DISP_OPC0
) (
    input  logic [OPC_W-1:0]                 opcode,
    input  logic [FN_W-1:0]                  fn,
    input  logic [NUM_DISP-1:0][UPC_W-1:0]   base_tbl,
    input  logic [NUM_DISP-1:0][FN_W-1:0]    mask_tbl,
    output logic [UPC_W-1:0]                 entry_upc
);

    always_comb begin
        entry_upc = UPC_W'(opcode);
        for (int k = 0; k < NUM_DISP; k++) begin
            if (int'(opcode) == DISP_OPC0 + k) begin
                entry_upc = base_tbl[k] + UPC_W'(fn & mask_tbl[k]);
            end
        end
    end

endmodule

// File: rtl/ucode_dispatch_seq.sv
// Microcode dispatcher/sequencer: accepts an instruction, then issues micro-PCs against a 1-cycle ROM.
// Define UCODE_BASE_WR_EN to make the dispatch base table writable at run time.
module ucode_dispatch_seq
    import ucode_pkg::*;
#(
    parameter int OPC_W     = ucode_pkg::OPC_W,
    parameter int FN_W      = ucode_pkg::FN_W,
    parameter int UPC_W     = ucode_pkg::UPC_W,
    parameter int NUM_DISP  = ucode_pkg::NUM_DISP,
    parameter int DISP_OPC0 = ucode_pkg::DISP_OPC0,
    parameter int MAX_UOPS  = ucode_pkg::MAX_UOPS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [OPC_W-1:0]             instr_opcode,
    input  logic [FN_W-1:0]              instr_fn,
    input  logic                         stall,
    output logic                         upc_valid,
    output logic [UPC_W-1:0]             upc,
    input  logic                         rsp_valid,
    input  logic                         rsp_last,
    input  logic                         rsp_branch,
    input  logic [UPC_W-1:0]             rsp_tgt,
    output logic                         done,
    output logic                         busy,
    output logic                         err_overrun
`ifdef UCODE_BASE_WR_EN
    ,
    input  logic                         base_wr_en,
    input  logic [$clog2(NUM_DISP)-1:0]  base_wr_idx,
    input  logic [UPC_W-1:0]             base_wr_data
`endif
);

    localparam int CNT_W = $clog2(MAX_UOPS + 1);

    useq_state_t                      state_q, state_d;
    logic [UPC_W-1:0]                 upc_q, upc_d;
    logic [CNT_W-1:0]                 uop_cnt_q, uop_cnt_d;
    logic                             err_q, err_d;
    logic                             issue;
    logic                             done_pulse;
    logic                             wd_trip;
    logic [UPC_W-1:0]                 entry_upc;
    logic [NUM_DISP-1:0][UPC_W-1:0]   def_base;
    logic [NUM_DISP-1:0][UPC_W-1:0]   base_tbl;
    logic [NUM_DISP-1:0][FN_W-1:0]    mask_tbl;

    for (genvar k = 0; k < NUM_DISP; k++) begin : g_def
        assign def_base[k] = UPC_W'(default_base(k));
        assign mask_tbl[k] = FN_W'(default_mask(k));
    end

`ifdef UCODE_BASE_WR_EN
    logic [NUM_DISP-1:0][UPC_W-1:0] base_q, base_d;

    // Writes land only while idle so a routine never sees its table change mid-flight.
    always_comb begin
        base_d = base_q;
        if (base_wr_en && state_q == IDLE) begin
            base_d[base_wr_idx] = base_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= def_base;
        end else begin
            base_q <= base_d;
        end
    end

    assign base_tbl = base_q;
`else
    assign base_tbl = def_base;
`endif

    ucode_entry_calc #(
        .OPC_W     (OPC_W),
        .FN_W      (FN_W),
        .UPC_W     (UPC_W),
        .NUM_DISP  (NUM_DISP),
        .DISP_OPC0 (DISP_OPC0)
    ) u_entry (
        .opcode    (instr_opcode),
        .fn        (instr_fn),
        .base_tbl  (base_tbl),
        .mask_tbl  (mask_tbl),
        .entry_upc (entry_upc)
    );

    // Watchdog trips when the next issue would push the per-instruction count past MAX_UOPS.
    assign wd_trip = (uop_cnt_q >= CNT_W'(MAX_UOPS));

    always_comb begin
        state_d    = state_q;
        upc_d      = upc_q;
        uop_cnt_d  = uop_cnt_q;
        err_d      = err_q;
        issue      = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: begin
                if (instr_valid) begin
                    upc_d     = entry_upc;
                    uop_cnt_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    if (wd_trip) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        issue     = 1'b1;
                        uop_cnt_d = uop_cnt_q + 1'b1;
                        state_d   = WAIT;
                    end
                end
            end
            WAIT: begin
                if (rsp_valid) begin
                    if (rsp_last) begin
                        done_pulse = 1'b1;
                        state_d    = IDLE;
                    end else if (rsp_branch) begin
                        upc_d   = rsp_tgt;
                        state_d = ISSUE;
                    end else begin
                        upc_d   = upc_q + 1'b1;
                        err_d   = err_q | (&upc_q);
                        state_d = ISSUE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            upc_q     <= '0;
            uop_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            upc_q     <= upc_d;
            uop_cnt_q <= uop_cnt_d;
            err_q     <= err_d;
        end
    end

    assign instr_ready = (state_q == IDLE);
    assign upc_valid   = issue;
    assign upc         = upc_q;
    assign done        = done_pulse;
    assign busy        = (state_q != IDLE);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_ucode_dispatch_seq.sv
// Scoreboard bench for ucode_dispatch_seq: directed instructions, a ROM responder and an issue/done monitor.
// Covers the writable base table when UCODE_BASE_WR_EN is defined.
module tb_ucode_dispatch_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_opcode = '0;
    logic [4:0]  instr_fn = '0;
    logic        stall = 1'b0;
    logic        upc_valid;
    logic [15:0] upc;
    logic        rsp_valid = 1'b0;
    logic        rsp_last = 1'b0;
    logic        rsp_branch = 1'b0;
    logic [15:0] rsp_tgt = '0;
    logic        done;
    logic        busy;
    logic        err_overrun;
`ifdef UCODE_BASE_WR_EN
    logic        base_wr_en = 1'b0;
    logic [1:0]  base_wr_idx = '0;
    logic [15:0] base_wr_data = '0;
`endif

    typedef struct {
        logic        last;
        logic        branch;
        logic [15:0] tgt;
    } rsp_t;

    rsp_t        rsp_q[$];
    logic [15:0] exp_upc_q[$];
    logic [15:0] exp_done_q[$];
    rsp_t        cur_rsp;
    int          checks = 0;
    int          failures = 0;

    ucode_dispatch_seq dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_opcode (instr_opcode),
        .instr_fn     (instr_fn),
        .stall        (stall),
        .upc_valid    (upc_valid),
        .upc          (upc),
        .rsp_valid    (rsp_valid),
        .rsp_last     (rsp_last),
        .rsp_branch   (rsp_branch),
        .rsp_tgt      (rsp_tgt),
        .done         (done),
        .busy         (busy),
        .err_overrun  (err_overrun)
`ifdef UCODE_BASE_WR_EN
        ,
        .base_wr_en   (base_wr_en),
        .base_wr_idx  (base_wr_idx),
        .base_wr_data (base_wr_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every issued upc and every done pulse is matched against the scoreboard queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && upc_valid) begin
                if (exp_upc_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_issue: got upc 0x%0h expected no issue", upc);
                end else begin
                    checkOutput("issue_upc", 32'(upc), 32'(exp_upc_q.pop_front()));
                end
            end
            if (rst_n && done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_done: got done at upc 0x%0h expected no done", upc);
                end else begin
                    checkOutput("done_upc", 32'(upc), 32'(exp_done_q.pop_front()));
                end
            end
        end
    end

    // ROM model: answers each issue one cycle later; plain sequential step when nothing is queued.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && upc_valid) begin
                @(posedge clk);
                #1;
                if (rsp_q.size() != 0) cur_rsp = rsp_q.pop_front();
                else cur_rsp = '{last: 1'b0, branch: 1'b0, tgt: 16'h0000};
                rsp_valid  = 1'b1;
                rsp_last   = cur_rsp.last;
                rsp_branch = cur_rsp.branch;
                rsp_tgt    = cur_rsp.tgt;
                @(posedge clk);
                #1;
                rsp_valid  = 1'b0;
                rsp_last   = 1'b0;
                rsp_branch = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] simulation timeout");
    end

    task automatic applyStimulus(input logic [3:0] opc, input logic [4:0] fn);
        @(posedge clk);
        #1;
        checkOutput("instr_ready_before_accept", 32'(instr_ready), 32'd1);
        instr_valid  = 1'b1;
        instr_opcode = opc;
        instr_fn     = fn;
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic pushRsp(input logic last, input logic branch, input logic [15:0] tgt);
        rsp_q.push_back('{last: last, branch: branch, tgt: tgt});
    endtask

    task automatic waitIdle(input string name, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || exp_upc_q.size() != 0 || exp_done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_busy_clear"}, 32'(busy), 32'd0);
        checkOutput({name, "_pending_expectations"},
                    32'(exp_upc_q.size() + exp_done_q.size() + rsp_q.size()), 32'd0);
        exp_upc_q.delete();
        exp_done_q.delete();
        rsp_q.delete();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [3:0]  tbl_opc [5] = '{4'd9, 4'd10, 4'd5, 4'd6, 4'd8};
    logic [4:0]  tbl_fn  [5] = '{5'h1F, 5'h07, 5'h1F, 5'h1C, 5'h00};
    logic [15:0] tbl_exp [5] = '{16'h0075, 16'h000A, 16'h0005, 16'h0012, 16'h0036};

    initial begin
        #1;
        checkOutput("reset_upc_valid", 32'(upc_valid), 32'd0);
        checkOutput("reset_upc", 32'(upc), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err_overrun), 32'd0);
        checkOutput("reset_ready", 32'(instr_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] sequential routine opc=6 fn=3");
        exp_upc_q = '{16'h0009, 16'h000A, 16'h000B};
        exp_done_q.push_back(16'h000B);
        pushRsp(0, 0, 16'h0000);
        pushRsp(0, 0, 16'h0000);
        pushRsp(1, 0, 16'h0000);
        applyStimulus(4'd6, 5'h03);
        @(negedge clk);
        checkOutput("first_issue_latency", 32'(upc_valid), 32'd1);
        waitIdle("seq_routine", 50);

        $display("[TB] masked function fields");
        exp_upc_q.push_back(16'h0029);
        exp_done_q.push_back(16'h0029);
        pushRsp(1, 0, 16'h0000);
        applyStimulus(4'd7, 5'h13);
        waitIdle("opc7_mask", 20);
        exp_upc_q.push_back(16'h0055);
        exp_done_q.push_back(16'h0055);
        pushRsp(1, 0, 16'h0000);
        applyStimulus(4'd8, 5'h1F);
        waitIdle("opc8_mask", 20);

        $display("[TB] non-dispatch opcode with branch, last beats branch");
        exp_upc_q = '{16'h0002, 16'h0100};
        exp_done_q.push_back(16'h0100);
        pushRsp(0, 1, 16'h0100);
        pushRsp(1, 1, 16'h0300);
        applyStimulus(4'd2, 5'h15);
        waitIdle("branch", 30);

        for (int i = 0; i < 5; i++) begin
            exp_upc_q.push_back(tbl_exp[i]);
            exp_done_q.push_back(tbl_exp[i]);
            pushRsp(1, 0, 16'h0000);
            applyStimulus(tbl_opc[i], tbl_fn[i]);
            waitIdle("entry_table", 20);
        end

        $display("[TB] stall held in ISSUE");
        exp_upc_q.push_back(16'h0058);
        exp_done_q.push_back(16'h0058);
        pushRsp(1, 0, 16'h0000);
        stall = 1'b1;
        applyStimulus(4'd9, 5'h02);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stall_upc_valid", 32'(upc_valid), 32'd0);
            checkOutput("stall_upc_hold", 32'(upc), 32'h0058);
            checkOutput("stall_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        waitIdle("stall", 20);
        checkOutput("err_before_watchdog", 32'(err_overrun), 32'd0);

        $display("[TB] watchdog: routine without last");
        for (int i = 0; i < 64; i++) exp_upc_q.push_back(16'(16'h0002 + i));
        applyStimulus(4'd2, 5'h00);
        waitIdle("watchdog", 300);
        checkOutput("watchdog_err", 32'(err_overrun), 32'd1);
        repeat (4) @(negedge clk);
        checkOutput("watchdog_err_sticky", 32'(err_overrun), 32'd1);

        $display("[TB] upc wrap");
        doReset();
        checkOutput("err_cleared_by_reset", 32'(err_overrun), 32'd0);
        exp_upc_q = '{16'h0003, 16'hFFFF, 16'h0000};
        exp_done_q.push_back(16'h0000);
        pushRsp(0, 1, 16'hFFFF);
        pushRsp(0, 0, 16'h0000);
        pushRsp(1, 0, 16'h0000);
        applyStimulus(4'd3, 5'h00);
        waitIdle("wrap", 30);
        checkOutput("wrap_err", 32'(err_overrun), 32'd1);

        $display("[TB] reset in WAIT");
        exp_upc_q.push_back(16'h0006);
        applyStimulus(4'd6, 5'h00);
        @(posedge clk);
        #3;
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_busy", 32'(busy), 32'd0);
        checkOutput("async_reset_upc", 32'(upc), 32'd0);
        checkOutput("async_reset_upc_valid", 32'(upc_valid), 32'd0);
        checkOutput("async_reset_done", 32'(done), 32'd0);
        checkOutput("async_reset_err", 32'(err_overrun), 32'd0);
        checkOutput("async_reset_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        waitIdle("after_reset", 10);

`ifdef UCODE_BASE_WR_EN
        $display("[TB] base table write");
        @(posedge clk);
        #1;
        base_wr_en   = 1'b1;
        base_wr_idx  = 2'd0;
        base_wr_data = 16'h0200;
        @(posedge clk);
        #1;
        base_wr_en = 1'b0;
        exp_upc_q.push_back(16'h0201);
        exp_done_q.push_back(16'h0201);
        pushRsp(1, 0, 16'h0000);
        applyStimulus(4'd6, 5'h01);
        waitIdle("base_write", 20);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
